// File: rtl/alu_share_ctrl.sv
// Round-robin owner of a single shared ALU: grants one of two requesters, holds the
// ALU inputs in registers for the opcode's settle time, then hands back the result.
module alu_share_ctrl #(
    parameter int N          = 15,
    parameter int MUL_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [2:0] op0,
    input  logic [N:0] a0,
    input  logic [N:0] b0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [2:0] op1,
    input  logic [N:0] a1,
    input  logic [N:0] b1,
    output logic       gnt1,
    output logic [N:0] alu_in0,
    output logic [N:0] alu_in1,
    output logic [2:0] alu_op,
    input  logic [N:0] alu_out,
    output logic [N:0] res,
    output logic       res_zero,
    output logic       res_id,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy
);

    // Result handshake: res/res_id/res_zero are valid while res_valid is high and are
    // held until the edge where res_valid & res_ready, after which res_valid drops.
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [N:0]    in0_q, in0_d;
    logic [N:0]    in1_q, in1_d;
    logic [2:0]    op_q, op_d;
    logic [N:0]    res_q, res_d;
    logic          zero_q, zero_d;
    logic          id_q, id_d;
    logic          valid_q, valid_d;
    logic [2:0]    sel_op;

    // Grants are only offered from IDLE; on a tie the requester not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && state_q == S_IDLE) begin
            if (req0 && req1) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign sel_op = gnt1 ? op1 : op0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        id_d    = id_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    op_d    = sel_op;
                    in0_d   = gnt1 ? a1 : a0;
                    in1_d   = gnt1 ? b1 : b0;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    cnt_d   = (sel_op == 3'b111) ? CW'(MUL_CYCLES - 1) : '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_d   = alu_out;
                    zero_d  = (alu_out == '0);
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // last_q resets to 1 so requester 0 wins the first contest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            in0_q   <= '0;
            in1_q   <= '0;
            op_q    <= 3'b000;
            res_q   <= '0;
            zero_q  <= 1'b0;
            id_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign alu_in0   = in0_q;
    assign alu_in1   = in1_q;
    assign alu_op    = op_q;
    assign res       = res_q;
    assign res_zero  = zero_q;
    assign res_id    = id_q;
    assign res_valid = valid_q;
    assign busy      = (state_q == S_EXEC) || (state_q == S_DONE);

endmodule
